// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index WIDTH iterations; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mult_sign_unit.sv
// Sign handling around the unsigned core: operand magnitudes and sign on the way in,
// conditional two's-complement negate of the product on the way out.
module mult_sign_unit #(
    parameter int WIDTH = 4
) (
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 neg_apply,
    input  logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 neg,
    output logic [2*WIDTH-1:0]   result
);

    logic [1:0][WIDTH-1:0] operand;
    logic [1:0][WIDTH-1:0] magnitude;

    assign operand[0] = a;
    assign operand[1] = b;

    // -2^(W-1) negates to itself, which read as unsigned is exactly its magnitude.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            assign magnitude[gi] = (signed_mode && operand[gi][WIDTH-1])
                                 ? WIDTH'(~operand[gi] + 1'b1)
                                 : operand[gi];
        end
    endgenerate

    assign a_mag  = magnitude[0];
    assign b_mag  = magnitude[1];
    assign neg    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign result = neg_apply ? (2*WIDTH)'(~product + 1'b1) : product;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier, one bit of the multiplier per cycle, with
// per-operation signed/unsigned mode and back-to-back starts from DONE.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 finish,
    output logic [2*WIDTH-1:0]   result_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int ACC_W = 2*WIDTH + 1;
    localparam logic [CNT_W:0] ITERS = (CNT_W+1)'(WIDTH);

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_W:0]       count_reg;
    logic [ACC_W-1:0]     acc_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic                 neg_reg;
    logic                 mode_reg;

    logic                 accept;
    logic                 iterate;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_in;
    logic [2*WIDTH-1:0]   product_fixed;
    logic [WIDTH:0]       upper_sum;
    logic [ACC_W-1:0]     acc_step;

    mult_sign_unit #(.WIDTH(WIDTH)) u_sign (
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .neg_apply   (mode_reg & neg_reg),
        .product     (acc_reg[2*WIDTH-1:0]),
        .a_mag       (a_mag),
        .b_mag       (b_mag),
        .neg         (neg_in),
        .result      (product_fixed)
    );

    assign accept  = start && ((state_reg == IDLE) || (state_reg == DONE));
    // WIDTH iterations, then one more RUN cycle so DONE reads the settled accumulator.
    assign iterate = (state_reg == RUN) && (count_reg < ITERS);

    always_comb begin
        upper_sum = acc_reg[ACC_W-1:WIDTH] + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
        acc_step  = {1'b0, upper_sum, acc_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count_reg == ITERS) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_reg == RUN);
        finish = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            neg_reg    <= 1'b0;
            mode_reg   <= 1'b0;
            result_out <= '0;
        end else begin
            if (accept) begin
                mode_reg  <= signed_mode;
                neg_reg   <= neg_in;
                mcand_reg <= a_mag;
                acc_reg   <= {{(WIDTH+1){1'b0}}, b_mag};
                count_reg <= '0;
            end else if (iterate) begin
                acc_reg   <= acc_step;
                count_reg <= count_reg + 1'b1;
            end
            if ((state_reg == RUN) && (state_next == DONE)) begin
                result_out <= product_fixed;
            end
        end
    end

endmodule
